// File: rtl/evt_buf_serializer.sv
// Event-word buffer: words are captured into an inferred RAM and drained serially
// on a Send rising edge, with optional inter-word gap, bit-order select and replay.
module evt_buf_serializer #(
    parameter int WIDTH      = 12,
    parameter int AWIDTH     = 15,
    parameter int MSB_FIRST  = 1,
    parameter int GAP        = 0,
    parameter int AUTO_CLEAR = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              StrobeIn,
    input  logic [WIDTH-1:0]  DataIn,
    input  logic              Send,
    input  logic              Abort,
    output logic              DataStream,
    output logic              FrameOut,
    output logic              WordStart,
    output logic              Busy,
    output logic              Full,
    output logic              Overflow,
    output logic [AWIDTH:0]   WordCount
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int BW    = $clog2(WIDTH);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    localparam logic [7:0]     GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAPW, DONE} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state_q;
    logic [WIDTH-1:0] sreg_q, sreg_d, rd_q;
    logic [AWIDTH:0]  cnt_q, rdptr_q;
    logic [BW-1:0]    bit_q;
    logic [7:0]       gap_q;
    logic             send_q, ovf_q;
    logic             send_rise, busy, full, we;

    assign busy      = (state_q != IDLE);
    assign full      = (cnt_q == CNT_FULL);
    assign we        = StrobeIn & ~full & ~busy;
    assign send_rise = Send & ~send_q;

    always_comb begin
        sreg_d = sreg_q;
        if (MSB_FIRST != 0) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        else                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end

    // The read port continuously tracks rdptr_q, so the next word is already
    // waiting in rd_q when the current one finishes; a write to the address
    // being read is forwarded so a Send coincident with the first write works.
    always_ff @(posedge Clock) begin
        if (we) mem[cnt_q[AWIDTH-1:0]] <= DataIn;
        if (we && (cnt_q[AWIDTH-1:0] == rdptr_q[AWIDTH-1:0])) rd_q <= DataIn;
        else                                                 rd_q <= mem[rdptr_q[AWIDTH-1:0]];
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            rdptr_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            send_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            send_q <= Send;
            if (StrobeIn && !we) ovf_q <= 1'b1;
            if (we) cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    rdptr_q <= '0;
                    if (send_rise && (cnt_q != '0 || we)) state_q <= FETCH;
                end
                FETCH: begin
                    if (Abort) begin
                        state_q <= IDLE;
                        rdptr_q <= '0;
                    end else begin
                        sreg_q  <= rd_q;
                        rdptr_q <= (AWIDTH + 1)'(1);
                        bit_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Abort) begin
                        state_q <= IDLE;
                        rdptr_q <= '0;
                        bit_q   <= '0;
                    end else if (bit_q == BIT_LAST) begin
                        bit_q <= '0;
                        if (rdptr_q == cnt_q) begin
                            state_q <= DONE;
                        end else begin
                            sreg_q  <= rd_q;
                            rdptr_q <= rdptr_q + 1'b1;
                            gap_q   <= '0;
                            state_q <= (GAP == 0) ? SHIFT : GAPW;
                        end
                    end else begin
                        sreg_q <= sreg_d;
                        bit_q  <= bit_q + 1'b1;
                    end
                end
                GAPW: begin
                    if (Abort) begin
                        state_q <= IDLE;
                        rdptr_q <= '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= SHIFT;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                DONE: begin
                    rdptr_q <= '0;
                    if (AUTO_CLEAR != 0) cnt_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign FrameOut   = (state_q == SHIFT);
    assign DataStream = FrameOut & ((MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign WordStart  = FrameOut & (bit_q == '0);
    assign Busy       = busy;
    assign Full       = full;
    assign Overflow   = ovf_q;
    assign WordCount  = cnt_q;

endmodule

// File: tb/tb_evt_buf_serializer.sv
// Directed bench for evt_buf_serializer: three small-RAM instances share the
// inputs, covering MSB/GAP0, LSB/GAP3 and replay configurations.
module tb_evt_buf_serializer;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset, StrobeIn, Send, Abort;
    logic [11:0] DataIn;
    logic [2:0]  ds, fo, ws, bz, fl, ov;
    logic [2:0][4:0] wc;

    evt_buf_serializer #(.WIDTH(12), .AWIDTH(4), .MSB_FIRST(1), .GAP(0), .AUTO_CLEAR(1)) u_a (
        .Clock(Clock), .Reset(Reset), .StrobeIn(StrobeIn), .DataIn(DataIn), .Send(Send),
        .Abort(Abort), .DataStream(ds[0]), .FrameOut(fo[0]), .WordStart(ws[0]), .Busy(bz[0]),
        .Full(fl[0]), .Overflow(ov[0]), .WordCount(wc[0]));
    evt_buf_serializer #(.WIDTH(12), .AWIDTH(4), .MSB_FIRST(0), .GAP(3), .AUTO_CLEAR(1)) u_b (
        .Clock(Clock), .Reset(Reset), .StrobeIn(StrobeIn), .DataIn(DataIn), .Send(Send),
        .Abort(Abort), .DataStream(ds[1]), .FrameOut(fo[1]), .WordStart(ws[1]), .Busy(bz[1]),
        .Full(fl[1]), .Overflow(ov[1]), .WordCount(wc[1]));
    evt_buf_serializer #(.WIDTH(12), .AWIDTH(4), .MSB_FIRST(1), .GAP(0), .AUTO_CLEAR(0)) u_c (
        .Clock(Clock), .Reset(Reset), .StrobeIn(StrobeIn), .DataIn(DataIn), .Send(Send),
        .Abort(Abort), .DataStream(ds[2]), .FrameOut(fo[2]), .WordStart(ws[2]), .Busy(bz[2]),
        .Full(fl[2]), .Overflow(ov[2]), .WordCount(wc[2]));

    typedef struct {
        logic        strobe;
        logic [11:0] data;
        logic        send;
        logic [4:0]  wc;
        logic        full, ovf, busy;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [1023:0] sv;
    int nb, nws, ws1, first, last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b0; StrobeIn = 1'b0; Send = 1'b0; Abort = 1'b0;
        step;
        Reset = 1'b1;
    endtask

    task automatic wr(input logic [11:0] d);
        StrobeIn = 1'b1; DataIn = d;
        step;
        StrobeIn = 1'b0;
    endtask

    task automatic pulse_send(input int k, input string nm);
        Send = 1'b1;
        step;
        Send = 1'b0;
        chk({nm, "_fetch_frame"}, fo[k], 1'b0);
        chk({nm, "_fetch_busy"}, bz[k], 1'b1);
    endtask

    // Steps until the instance goes idle or maxbits bits were seen.
    task automatic collect(input int k, input int maxbits);
        sv = '0; nb = 0; nws = 0; ws1 = -1; first = -1; last = -1;
        for (int c = 0; c < 400; c++) begin
            step;
            if (fo[k]) begin
                if (first < 0) first = c;
                last = c;
                if (ws[k]) begin
                    if (nws == 1) ws1 = nb;
                    nws++;
                end
                sv = {sv[1022:0], ds[k]};
                nb++;
                if (nb == maxbits) return;
            end else if (!bz[k]) begin
                return;
            end
        end
        chk("collect_timeout", bz[k], 1'b0);
    endtask

    vec_t tbl [18];

    initial begin
        for (int i = 0; i < 17; i++) begin
            tbl[i].strobe = 1'b1;
            tbl[i].data   = 12'h100 + 12'(i);
            tbl[i].send   = 1'b0;
            tbl[i].wc     = (i < 16) ? 5'(i + 1) : 5'd16;
            tbl[i].full   = (i >= 15);
            tbl[i].ovf    = (i >= 16);
            tbl[i].busy   = 1'b0;
        end
        tbl[17] = '{strobe: 1'b0, data: 12'h0, send: 1'b0, wc: 5'd16, full: 1'b1, ovf: 1'b1, busy: 1'b0};

        Reset = 1'b0; StrobeIn = 1'b0; Send = 1'b0; Abort = 1'b0; DataIn = '0;
        step; step;
        Reset = 1'b1;
        step;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out%0d", k), {ds[k], fo[k], ws[k], bz[k], fl[k], ov[k]}, 6'b0);
            chk($sformatf("rst_wc%0d", k), wc[k], 5'd0);
        end

        // T1: MSB first, no gap
        do_reset;
        wr(12'hA5C); wr(12'h3F0);
        chk("t1_wc_loaded", wc[0], 5'd2);
        pulse_send(0, "t1");
        collect(0, 1000);
        chk("t1_latency", first, 0);
        chk("t1_nbits", nb, 24);
        chk("t1_bits", sv[23:0], 24'hA5C3F0);
        chk("t1_contig", (last - first + 1) - nb, 0);
        chk("t1_nws", nws, 2);
        chk("t1_ws1", ws1, 12);
        chk("t1_wc_after", wc[0], 5'd0);

        // T2: LSB first with a 3-cycle gap
        do_reset;
        wr(12'h001); wr(12'h800);
        pulse_send(1, "t2");
        collect(1, 1000);
        chk("t2_nbits", nb, 24);
        chk("t2_bits", sv[23:0], 24'h800001);
        chk("t2_gap", (last - first + 1) - nb, 3);
        chk("t2_ws1", ws1, 12);
        chk("t2_wc_after", wc[1], 5'd0);

        // T3: fill to full and overflow, table driven
        do_reset;
        for (int i = 0; i < 18; i++) begin
            StrobeIn = tbl[i].strobe; DataIn = tbl[i].data; Send = tbl[i].send;
            step;
            StrobeIn = 1'b0; Send = 1'b0;
            chk($sformatf("t3_wc[%0d]", i), wc[0], tbl[i].wc);
            chk($sformatf("t3_full[%0d]", i), fl[0], tbl[i].full);
            chk($sformatf("t3_ovf[%0d]", i), ov[0], tbl[i].ovf);
            chk($sformatf("t3_busy[%0d]", i), bz[0], tbl[i].busy);
        end
        pulse_send(0, "t3");
        collect(0, 1000);
        chk("t3_nbits", nb, 192);
        chk("t3_nws", nws, 16);
        chk("t3_word0", sv[191:180], 12'h100);
        chk("t3_word15", sv[11:0], 12'h10F);
        chk("t3_wc_after", wc[0], 5'd0);
        chk("t3_ovf_sticky", ov[0], 1'b1);
        chk("t3_full_after", fl[0], 1'b0);

        // T4: abort in the middle of word 2, then full resend
        do_reset;
        wr(12'h123); wr(12'h456); wr(12'h789); wr(12'hABC);
        pulse_send(0, "t4");
        collect(0, 18);
        chk("t4_prefix", sv[17:0], 18'h048D1);
        Abort = 1'b1;
        step;
        Abort = 1'b0;
        chk("t4_abort_out", {ds[0], fo[0], ws[0], bz[0]}, 4'b0);
        chk("t4_abort_wc", wc[0], 5'd4);
        pulse_send(0, "t4r");
        collect(0, 1000);
        chk("t4_nbits", nb, 48);
        chk("t4_bits", sv[47:0], 48'h123456789ABC);
        chk("t4_wc_after", wc[0], 5'd0);

        // T5: replay mode keeps the words
        do_reset;
        wr(12'h0F1); wr(12'hE2D); wr(12'h3C3);
        pulse_send(2, "t5a");
        collect(2, 1000);
        chk("t5a_bits", sv[35:0], 36'h0F1E2D3C3);
        chk("t5a_nbits", nb, 36);
        chk("t5a_wc", wc[2], 5'd3);
        pulse_send(2, "t5b");
        collect(2, 1000);
        chk("t5b_bits", sv[35:0], 36'h0F1E2D3C3);
        chk("t5b_nbits", nb, 36);
        chk("t5b_wc", wc[2], 5'd3);

        // T6: reset mid-shift, then Send on empty buffer
        do_reset;
        wr(12'hFFF); wr(12'hFFF);
        pulse_send(0, "t6");
        collect(0, 5);
        Reset = 1'b0;
        step;
        Reset = 1'b1;
        chk("t6_rst_out", {ds[0], fo[0], ws[0], bz[0], fl[0], ov[0]}, 6'b0);
        chk("t6_rst_wc", wc[0], 5'd0);
        Send = 1'b1;
        step;
        chk("t6_empty_busy0", bz[0], 1'b0);
        Send = 1'b0;
        step;
        chk("t6_empty_busy1", bz[0], 1'b0);
        chk("t6_empty_frame", fo[0], 1'b0);

        // Strobe and Send rise together on an empty buffer
        do_reset;
        StrobeIn = 1'b1; DataIn = 12'h5A5; Send = 1'b1;
        step;
        StrobeIn = 1'b0; Send = 1'b0;
        chk("sim_busy", bz[0], 1'b1);
        chk("sim_wc", wc[0], 5'd1);
        collect(0, 1000);
        chk("sim_nbits", nb, 12);
        chk("sim_bits", sv[11:0], 12'h5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
